kernal_rom_arbiter: RTL and testbench
=====================================

Name: kernal_rom_arbiter

Overview:
- Shares the single-port KERNAL ROM (BIOS words plus charset words, 32-bit data) between two requesters: the CPU instruction/data fetch port and the video character generator.
- Pipelined, one ROM access issued per cycle at most.
- The video port gets fixed priority; a bounded CPU wait guarantees forward progress.
- Sits between the CPU bus, the video unit and the KERNAL instance; the KERNAL is unmodified.

Parameters:
- CPU_MAX_WAIT, 4: max consecutive contested cycles the CPU may lose before it is forced a grant (1..15).
- CHARSET_BASE, 12'h400: ROM word address of charset entry 0; video index is ORed into bits [7:0].

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- cpu_req  in  1  CPU request valid; held with cpu_addr until granted
- cpu_addr  in  12  CPU ROM word address
- cpu_gnt  out  1  combinational; cpu_req&cpu_gnt = handshake at that edge
- cpu_rdata  out  32  CPU read data, valid when cpu_rvalid
- cpu_rvalid  out  1  one-cycle pulse per completed CPU access
- vid_req  in  1  video request valid; held with vid_idx until granted
- vid_idx  in  8  charset word index
- vid_gnt  out  1  combinational grant
- vid_rdata  out  32  charset data
- vid_rvalid  out  1  one-cycle pulse per completed video access
- rom_addr  out  12  registered address to KERNAL addr
- rom_data  in  32  KERNAL out

Behaviour:
- Reset (rst=0 at posedge): rom_addr=0, cpu_rdata=vid_rdata=0, cpu_rvalid=vid_rvalid=0, wait counter=0, pipeline valid bits cleared. Grants are forced 0 while rst=0.
- Grant decision, combinational in cycle N:
  - Only vid_req: vid_gnt=1.
  - Only cpu_req: cpu_gnt=1.
  - Both, with wait_cnt<CPU_MAX_WAIT: vid_gnt=1.
  - Both, with wait_cnt==CPU_MAX_WAIT: cpu_gnt=1.
  - Never both grants high at once.
- Wait counter (4-bit):
  - Increments when both requests are high and video wins.
  - Clears when the CPU is granted or cpu_req=0.
  - Saturates at CPU_MAX_WAIT.
- Issue, edge ending cycle N:
  - rom_addr <= cpu_addr (CPU win) or CHARSET_BASE|{4'b0,vid_idx} (video win).
  - Stage-1 tag <= {valid, owner}.
  - With no grant, rom_addr holds and the tag valid bit is 0.
- Pipeline, matching KERNAL behaviour (registered address and output-select; data is valid 1 cycle after rom_addr changes):
  - Stage-1 tag shifts to stage 2 at the edge ending N+1.
  - rom_data is valid during N+2.
  - At the edge ending N+2, the owner's rdata <= rom_data and the owner's rvalid goes 1.
  - rvalid is high during N+3 only.
- Latency: handshake cycle to rvalid = 3 cycles. Throughput: 1 access/cycle, back-to-back, mixed owners in any order.
- Ordering: responses return in grant order per port. Non-owner rdata holds its last value.
- Simultaneous response and new grant: independent, no stall.
- Reset mid-flight: in-flight tags are discarded. No rvalid follows reset release for pre-reset grants.
- rom_addr bit 11 is passed through from cpu_addr unmodified. The KERNAL address decode is the KERNAL's responsibility.

Test Plan:
- Reset, then cpu_req=1 with cpu_addr=12'h010 for 1 cycle: cpu_gnt=1 that cycle; rom_addr=0x010 next cycle; cpu_rvalid pulses 3 cycles after the handshake with cpu_rdata=bios word 0x010. vid_rvalid stays 0.
- vid_req with vid_idx=8'h41, then 8'h42 back-to-back: rom_addr=0x441, then 0x442. vid_rvalid is high 2 consecutive cycles with charset words 0x41 and 0x42, in order.
- Both requests held continuously, CPU_MAX_WAIT=4: grant sequence V,V,V,V,C,V,V,V,V,C…; the CPU is granted exactly every 5th cycle.
- Interleaved CPU and video grants: each rvalid goes only to its owner, each at exactly +3 cycles; the non-owner rdata is unchanged.
- Grant issued, then rst=0 for 1 cycle on the next edge: no rvalid afterwards, rom_addr=0, wait counter=0.
- cpu_req held with cpu_addr=12'hFFF: granted; rom_addr=0xFFF; cpu_rvalid at +3 with rom_data passed through.

Source files
------------

// File: rtl/kernal_rom_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | kernal_rom_arbiter: shares the single-port KERNAL ROM between the CPU     |
// | fetch port and the video charset port; pipelined, one access per cycle.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module kernal_rom_arbiter #(
  parameter int unsigned CPU_MAX_WAIT = 4,
  parameter logic [11:0] CHARSET_BASE = 12'h400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [11:0] cpu_addr,
  output logic        cpu_gnt,
  output logic [31:0] cpu_rdata,
  output logic        cpu_rvalid,
  input  logic        vid_req,
  input  logic [7:0]  vid_idx,
  output logic        vid_gnt,
  output logic [31:0] vid_rdata,
  output logic        vid_rvalid,
  output logic [11:0] rom_addr,
  input  logic [31:0] rom_data
);

  localparam logic [3:0] c_max_wait = 4'(CPU_MAX_WAIT);

  logic [3:0] r_wait_cnt;
  logic       r_s1_valid;
  logic       r_s1_cpu;
  logic       r_s2_valid;
  logic       r_s2_cpu;
  logic       w_cpu_win;
  logic       w_vid_win;

  // Video has fixed priority unless the CPU has already lost c_max_wait contests.
  always_comb begin
    w_cpu_win = 1'b0;
    w_vid_win = 1'b0;
    if (rst) begin
      if (cpu_req && (!vid_req || (r_wait_cnt >= c_max_wait))) begin
        w_cpu_win = 1'b1;
      end else if (vid_req) begin
        w_vid_win = 1'b1;
      end
    end
  end

  assign cpu_gnt = w_cpu_win;
  assign vid_gnt = w_vid_win;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wait_cnt <= 4'd0;
      rom_addr   <= 12'd0;
      r_s1_valid <= 1'b0;
      r_s1_cpu   <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_cpu   <= 1'b0;
      cpu_rdata  <= 32'd0;
      cpu_rvalid <= 1'b0;
      vid_rdata  <= 32'd0;
      vid_rvalid <= 1'b0;
    end else begin
      if (w_vid_win && cpu_req) begin
        if (r_wait_cnt < c_max_wait) begin
          r_wait_cnt <= r_wait_cnt + 4'd1;
        end
      end else begin
        r_wait_cnt <= 4'd0;
      end

      if (w_cpu_win) begin
        rom_addr <= cpu_addr;
      end else if (w_vid_win) begin
        rom_addr <= CHARSET_BASE | {4'b0000, vid_idx};
      end

      // The ROM registers the address, so data for a stage-2 tag is on rom_data now.
      r_s1_valid <= w_cpu_win | w_vid_win;
      r_s1_cpu   <= w_cpu_win;
      r_s2_valid <= r_s1_valid;
      r_s2_cpu   <= r_s1_cpu;

      cpu_rvalid <= r_s2_valid & r_s2_cpu;
      vid_rvalid <= r_s2_valid & ~r_s2_cpu;
      if (r_s2_valid && r_s2_cpu) begin
        cpu_rdata <= rom_data;
      end
      if (r_s2_valid && !r_s2_cpu) begin
        vid_rdata <= rom_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_kernal_rom_arbiter.sv
`default_nettype none
// Bench for kernal_rom_arbiter: random and directed stimulus against a
// response-queue model with a registered-address ROM stand-in.
module tb_kernal_rom_arbiter;

  localparam int          CPU_MAX_WAIT = 4;
  localparam logic [11:0] CHARSET_BASE = 12'h400;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [11:0] cpu_addr;
  logic        cpu_gnt;
  logic [31:0] cpu_rdata;
  logic        cpu_rvalid;
  logic        vid_req;
  logic [7:0]  vid_idx;
  logic        vid_gnt;
  logic [31:0] vid_rdata;
  logic        vid_rvalid;
  logic [11:0] rom_addr;
  logic [31:0] rom_data;

  kernal_rom_arbiter #(
    .CPU_MAX_WAIT(CPU_MAX_WAIT),
    .CHARSET_BASE(CHARSET_BASE)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt),
    .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .vid_req(vid_req), .vid_idx(vid_idx), .vid_gnt(vid_gnt),
    .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [11:0] a);
    return {~a[7:0], a, a ^ 12'hA5C};
  endfunction

  // ROM stand-in: data appears the cycle after the address is registered.
  always @(posedge clk) rom_data <= rom_word(rom_addr);

  typedef struct {
    int          due;
    bit          cpu;
    logic [11:0] addr;
  } rsp_t;

  rsp_t        exp_q[$];
  int          cyc = 0;
  int          m_wait = 0;
  int          checks = 0;
  int          errors = 0;
  logic [11:0] m_rom_addr = 12'd0;
  logic [31:0] m_cpu_rdata = 32'd0;
  logic [31:0] m_vid_rdata = 32'd0;
  bit          exp_cpu_gnt, exp_vid_gnt, exp_cpu_rvalid, exp_vid_rvalid;
  logic [79:0] obs, want;

  function automatic logic [79:0] dut_vec();
    return {cpu_gnt, vid_gnt, cpu_rvalid, vid_rvalid, rom_addr, cpu_rdata, vid_rdata};
  endfunction

  function automatic logic [79:0] model_vec();
    return {exp_cpu_gnt, exp_vid_gnt, exp_cpu_rvalid, exp_vid_rvalid, m_rom_addr,
            m_cpu_rdata, m_vid_rdata};
  endfunction

  // Expected values for the current cycle, evaluated mid-cycle.
  task automatic sample();
    @(negedge clk);
    exp_cpu_gnt    = rst && cpu_req && (!vid_req || m_wait >= CPU_MAX_WAIT);
    exp_vid_gnt    = rst && vid_req && !exp_cpu_gnt;
    exp_cpu_rvalid = 1'b0;
    exp_vid_rvalid = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      if (exp_q[0].cpu) begin
        exp_cpu_rvalid = 1'b1;
        m_cpu_rdata    = rom_word(exp_q[0].addr);
      end else begin
        exp_vid_rvalid = 1'b1;
        m_vid_rdata    = rom_word(exp_q[0].addr);
      end
      void'(exp_q.pop_front());
    end
  endtask

  // Apply the clock edge to the model, then leave 1 time unit for new stimulus.
  task automatic advance();
    logic [11:0] a;
    @(posedge clk);
    if (!rst) begin
      exp_q.delete();
      m_wait      = 0;
      m_rom_addr  = 12'd0;
      m_cpu_rdata = 32'd0;
      m_vid_rdata = 32'd0;
    end else if (exp_cpu_gnt) begin
      exp_q.push_back('{due: cyc + 3, cpu: 1'b1, addr: cpu_addr});
      m_rom_addr = cpu_addr;
      m_wait     = 0;
    end else if (exp_vid_gnt) begin
      a = CHARSET_BASE | {4'h0, vid_idx};
      exp_q.push_back('{due: cyc + 3, cpu: 1'b0, addr: a});
      m_rom_addr = a;
      m_wait     = cpu_req ? ((m_wait < CPU_MAX_WAIT) ? m_wait + 1 : m_wait) : 0;
    end else begin
      m_wait = 0;
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; cpu_req = 1'b1; cpu_addr = 12'h123; vid_req = 1'b1; vid_idx = 8'h07;
    advance();
    advance();
    sample();
    obs = dut_vec(); want = model_vec();
    checks++; if (obs !== want) begin errors++; $display("FAIL reset_state got=%h exp=%h", obs, want); end
    checks++; if ({cpu_gnt, vid_gnt, rom_addr} !== 14'd0) begin errors++;
      $display("FAIL reset_grants got=%b%b addr=%h exp=0", cpu_gnt, vid_gnt, rom_addr); end
    advance();
    rst = 1'b1; cpu_req = 1'b0; vid_req = 1'b0;
  endtask

  task automatic test_cpu_single();
    for (int i = 0; i < 6; i++) begin
      cpu_req = (i == 0); cpu_addr = 12'h010;
      sample();
      obs = dut_vec(); want = model_vec();
      checks++; if (obs !== want) begin errors++; $display("FAIL cpu_single cyc=%0d got=%h exp=%h", cyc, obs, want); end
      if (i == 1) begin
        checks++; if (rom_addr !== 12'h010) begin errors++; $display("FAIL cpu_single_addr got=%h exp=010", rom_addr); end
      end
      if (i == 3) begin
        checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== rom_word(12'h010) || vid_rvalid !== 1'b0) begin errors++;
          $display("FAIL cpu_single_rsp got=%b/%h exp=1/%h", cpu_rvalid, cpu_rdata, rom_word(12'h010)); end
      end
      advance();
    end
  endtask

  task automatic test_vid_b2b();
    int nvalid = 0;
    for (int i = 0; i < 7; i++) begin
      vid_req = (i < 2); vid_idx = (i == 0) ? 8'h41 : 8'h42;
      sample();
      obs = dut_vec(); want = model_vec();
      checks++; if (obs !== want) begin errors++; $display("FAIL vid_b2b cyc=%0d got=%h exp=%h", cyc, obs, want); end
      if (i == 3 || i == 4) begin
        nvalid++;
        checks++; if (vid_rvalid !== 1'b1 || vid_rdata !== rom_word(i == 3 ? 12'h441 : 12'h442)) begin errors++;
          $display("FAIL vid_b2b_rsp i=%0d got=%b/%h", i, vid_rvalid, vid_rdata); end
      end
      advance();
    end
    checks++; if (nvalid !== 2) begin errors++; $display("FAIL vid_b2b_count got=%0d exp=2", nvalid); end
  endtask

  task automatic test_starvation();
    int ncpu = 0;
    cpu_req = 1'b1; vid_req = 1'b1; cpu_addr = 12'($urandom); vid_idx = 8'($urandom);
    for (int i = 0; i < 20; i++) begin
      sample();
      obs = dut_vec(); want = model_vec();
      checks++; if (obs !== want) begin errors++; $display("FAIL starve cyc=%0d got=%h exp=%h", cyc, obs, want); end
      checks++; if (cpu_gnt !== ((i % 5) == 4)) begin errors++;
        $display("FAIL starve_pattern i=%0d got=%b exp=%b", i, cpu_gnt, (i % 5) == 4); end
      if (cpu_gnt === 1'b1) ncpu++;
      advance();
      if (exp_cpu_gnt) cpu_addr = 12'($urandom);
      if (exp_vid_gnt) vid_idx = 8'($urandom);
    end
    checks++; if (ncpu !== 4) begin errors++; $display("FAIL starve_count got=%0d exp=4", ncpu); end
    cpu_req = 1'b0; vid_req = 1'b0;
  endtask

  task automatic test_interleaved();
    for (int i = 0; i < 16; i++) begin
      cpu_req = (i < 12) && (i % 2 == 0); cpu_addr = 12'($urandom);
      vid_req = (i < 12) && (i % 2 == 1); vid_idx = 8'($urandom);
      sample();
      obs = dut_vec(); want = model_vec();
      checks++; if (obs !== want) begin errors++; $display("FAIL interleave cyc=%0d got=%h exp=%h", cyc, obs, want); end
      advance();
    end
  endtask

  task automatic test_random();
    cpu_req = 1'b0; vid_req = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!cpu_req || exp_cpu_gnt) begin
        cpu_req = ($urandom_range(0, 99) < 60); cpu_addr = 12'($urandom);
      end
      if (!vid_req || exp_vid_gnt) begin
        vid_req = ($urandom_range(0, 99) < 55); vid_idx = 8'($urandom);
      end
      if (i >= 395) begin cpu_req = 1'b0; vid_req = 1'b0; end
      sample();
      obs = dut_vec(); want = model_vec();
      checks++; if (obs !== want) begin errors++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, want); end
      advance();
    end
  endtask

  task automatic test_reset_midflight();
    int nvalid = 0;
    cpu_req = 1'b1; cpu_addr = 12'h2A5;
    sample();
    obs = dut_vec(); want = model_vec();
    checks++; if (obs !== want) begin errors++; $display("FAIL midrst_issue got=%h exp=%h", obs, want); end
    advance();
    cpu_req = 1'b0; rst = 1'b0;
    sample();
    advance();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sample();
      obs = dut_vec(); want = model_vec();
      checks++; if (obs !== want) begin errors++; $display("FAIL midrst cyc=%0d got=%h exp=%h", cyc, obs, want); end
      if (cpu_rvalid !== 1'b0 || vid_rvalid !== 1'b0) nvalid++;
      if (i == 0) begin
        checks++; if (rom_addr !== 12'h000) begin errors++; $display("FAIL midrst_addr got=%h exp=000", rom_addr); end
      end
      advance();
    end
    checks++; if (nvalid !== 0) begin errors++; $display("FAIL midrst_rvalid got=%0d exp=0", nvalid); end
  endtask

  task automatic test_addr_fff();
    for (int i = 0; i < 5; i++) begin
      cpu_req = (i == 0); cpu_addr = 12'hFFF;
      sample();
      obs = dut_vec(); want = model_vec();
      checks++; if (obs !== want) begin errors++; $display("FAIL addr_fff cyc=%0d got=%h exp=%h", cyc, obs, want); end
      if (i == 1) begin
        checks++; if (rom_addr !== 12'hFFF) begin errors++; $display("FAIL addr_fff_rom got=%h exp=fff", rom_addr); end
      end
      if (i == 3) begin
        checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== rom_word(12'hFFF)) begin errors++;
          $display("FAIL addr_fff_rsp got=%b/%h exp=1/%h", cpu_rvalid, cpu_rdata, rom_word(12'hFFF)); end
      end
      advance();
    end
  endtask

  initial begin
    rst = 1'b0; cpu_req = 1'b0; cpu_addr = 12'd0; vid_req = 1'b0; vid_idx = 8'd0;
    test_reset();
    test_cpu_single();
    test_vid_b2b();
    test_starvation();
    test_interleaved();
    test_random();
    test_reset_midflight();
    test_addr_fff();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
